mips_mc_control: RTL and testbench

Multi-cycle main control FSM for the MIPS core. Decodes the 6-bit opcode and sequences the shared datapath (single ALU, unified instruction/data memory, register file, PC) over 3-5 cycles per instruction. It drives `ALUop_o` into `ALUControl`, which in turn drives `aluControl_i` of `alu`. `zero_o` from `alu` is combined with `branch_o` outside this block to form the PC enable.

---
 rtl/mips_mc_control.sv | 200 ++++++++++++++++++++
 tb/tb_mips_mc_control.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_control.sv
// mips_mc_control: multi-cycle main control FSM for the MIPS core.
// Decodes the opcode and sequences the shared datapath over 3-5 cycles.
// Optional feature macro: MC_CONTROL_BNE_EN adds bne (BRANCH_NE state, branchNe_o port).
module mips_mc_control #(
  parameter int unsigned OP_W = 6
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [OP_W-1:0] opcode_i,
  input  logic            mem_ready_i,
  output logic            IorD_o,
  output logic            memWrite_o,
  output logic            IRWrite_o,
  output logic            regDst_o,
  output logic            memtoReg_o,
  output logic            regWrite_o,
  output logic            aluSrcA_o,
  output logic [1:0]      aluSrcB_o,
  output logic [1:0]      ALUop_o,
  output logic [1:0]      PCSrc_o,
  output logic            PCWrite_o,
  output logic            branch_o,
  output logic            illegal_o,
  output logic [3:0]      state_o
`ifdef MC_CONTROL_BNE_EN
  ,
  output logic            branchNe_o
`endif
);

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXECUTE = 4'd6;
  localparam logic [3:0] S_ALUWB   = 4'd7;
  localparam logic [3:0] S_BRANCH  = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JUMP    = 4'd11;
`ifdef MC_CONTROL_BNE_EN
  localparam logic [3:0] S_BRNE    = 4'd12;
`endif

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
`ifdef MC_CONTROL_BNE_EN
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'b000101);
`endif

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic [3:0] w_st;
  logic       w_illegal;
  logic       w_mem_write;
  logic       w_reg_write;
  logic       w_ir_write;
  logic       w_pc_write;
  logic       w_branch;

  // State register; reset aborts whatever instruction is in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; opcode is only consulted in DECODE and MEMADR.
  always_comb begin
    w_next    = S_FETCH;
    w_illegal = 1'b0;
    case (r_state)
      S_FETCH:  w_next = mem_ready_i ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode_i)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXECUTE;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
`ifdef MC_CONTROL_BNE_EN
          OP_BNE:       w_next = S_BRNE;
`endif
          default: begin
            w_next    = S_FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        if (opcode_i == OP_LW) begin
          w_next = S_MEMRD;
        end else if (opcode_i == OP_SW) begin
          w_next = S_MEMWR;
        end else begin
          w_next = S_FETCH;
        end
      end
      S_MEMRD:   w_next = mem_ready_i ? S_MEMWB : S_MEMRD;
      S_MEMWB:   w_next = S_FETCH;
      S_MEMWR:   w_next = mem_ready_i ? S_FETCH : S_MEMWR;
      S_EXECUTE: w_next = S_ALUWB;
      S_ALUWB:   w_next = S_FETCH;
      S_BRANCH:  w_next = S_FETCH;
      S_ADDIEX:  w_next = S_ADDIWB;
      S_ADDIWB:  w_next = S_FETCH;
      S_JUMP:    w_next = S_FETCH;
      default:   w_next = S_FETCH;
    endcase
  end

  // During reset the datapath selects show FETCH values regardless of state.
  assign w_st = rst_i ? S_FETCH : r_state;

  // Output decode from state; FETCH strobes follow mem_ready_i (Mealy).
  always_comb begin
    IorD_o      = 1'b0;
    w_mem_write = 1'b0;
    w_ir_write  = 1'b0;
    regDst_o    = 1'b0;
    memtoReg_o  = 1'b0;
    w_reg_write = 1'b0;
    aluSrcA_o   = 1'b0;
    aluSrcB_o   = 2'b00;
    ALUop_o     = 2'b00;
    PCSrc_o     = 2'b00;
    w_pc_write  = 1'b0;
    w_branch    = 1'b0;
`ifdef MC_CONTROL_BNE_EN
    branchNe_o  = 1'b0;
`endif
    case (w_st)
      S_FETCH: begin
        aluSrcB_o  = 2'b01;
        w_ir_write = mem_ready_i;
        w_pc_write = mem_ready_i;
      end
      S_DECODE: aluSrcB_o = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        aluSrcA_o = 1'b1;
        aluSrcB_o = 2'b10;
      end
      S_MEMRD: IorD_o = 1'b1;
      S_MEMWB: begin
        memtoReg_o  = 1'b1;
        w_reg_write = 1'b1;
      end
      S_MEMWR: begin
        IorD_o      = 1'b1;
        w_mem_write = 1'b1;
      end
      S_EXECUTE: begin
        aluSrcA_o = 1'b1;
        ALUop_o   = 2'b10;
      end
      S_ALUWB: begin
        regDst_o    = 1'b1;
        w_reg_write = 1'b1;
      end
      S_BRANCH: begin
        aluSrcA_o = 1'b1;
        ALUop_o   = 2'b01;
        PCSrc_o   = 2'b01;
        w_branch  = 1'b1;
      end
`ifdef MC_CONTROL_BNE_EN
      S_BRNE: begin
        aluSrcA_o  = 1'b1;
        ALUop_o    = 2'b01;
        PCSrc_o    = 2'b01;
        branchNe_o = 1'b1;
      end
`endif
      S_ADDIWB: w_reg_write = 1'b1;
      S_JUMP: begin
        PCSrc_o    = 2'b10;
        w_pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  // Write strobes and the illegal pulse are suppressed in the reset cycle.
  assign memWrite_o = w_mem_write & ~rst_i;
  assign regWrite_o = w_reg_write & ~rst_i;
  assign IRWrite_o  = w_ir_write  & ~rst_i;
  assign PCWrite_o  = w_pc_write  & ~rst_i;
  assign branch_o   = w_branch    & ~rst_i;
  assign illegal_o  = w_illegal   & ~rst_i;
  assign state_o    = r_state;

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed testbench for mips_mc_control with a small behavioural ALU/ALUControl.
module tb_mips_mc_control;

  logic       clk = 1'b0;
  logic       rst_i;
  logic [5:0] opcode_i;
  logic       mem_ready_i;
  logic       IorD_o, memWrite_o, IRWrite_o, regDst_o, memtoReg_o, regWrite_o, aluSrcA_o;
  logic [1:0] aluSrcB_o, ALUop_o, PCSrc_o;
  logic       PCWrite_o, branch_o, illegal_o;
  logic [3:0] state_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mips_mc_control #(.OP_W(6)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .opcode_i    (opcode_i),
    .mem_ready_i (mem_ready_i),
    .IorD_o      (IorD_o),
    .memWrite_o  (memWrite_o),
    .IRWrite_o   (IRWrite_o),
    .regDst_o    (regDst_o),
    .memtoReg_o  (memtoReg_o),
    .regWrite_o  (regWrite_o),
    .aluSrcA_o   (aluSrcA_o),
    .aluSrcB_o   (aluSrcB_o),
    .ALUop_o     (ALUop_o),
    .PCSrc_o     (PCSrc_o),
    .PCWrite_o   (PCWrite_o),
    .branch_o    (branch_o),
    .illegal_o   (illegal_o),
    .state_o     (state_o)
  );

  // Packed view: IorD memWrite IRWrite regDst memtoReg regWrite aluSrcA
  //              aluSrcB[2] ALUop[2] PCSrc[2] PCWrite branch illegal
  logic [15:0] obs;
  assign obs = {IorD_o, memWrite_o, IRWrite_o, regDst_o, memtoReg_o, regWrite_o, aluSrcA_o,
                aluSrcB_o, ALUop_o, PCSrc_o, PCWrite_o, branch_o, illegal_o};

  localparam logic [15:0] O_FR   = 16'b0_0_1_0_0_0_0_01_00_00_1_0_0; // FETCH, ready
  localparam logic [15:0] O_FN   = 16'b0_0_0_0_0_0_0_01_00_00_0_0_0; // FETCH idle / reset
  localparam logic [15:0] O_DEC  = 16'b0_0_0_0_0_0_0_11_00_00_0_0_0;
  localparam logic [15:0] O_ILL  = 16'b0_0_0_0_0_0_0_11_00_00_0_0_1;
  localparam logic [15:0] O_MADR = 16'b0_0_0_0_0_0_1_10_00_00_0_0_0; // also ADDIEX
  localparam logic [15:0] O_MRD  = 16'b1_0_0_0_0_0_0_00_00_00_0_0_0;
  localparam logic [15:0] O_MWB  = 16'b0_0_0_0_1_1_0_00_00_00_0_0_0;
  localparam logic [15:0] O_MWR  = 16'b1_1_0_0_0_0_0_00_00_00_0_0_0;
  localparam logic [15:0] O_EXE  = 16'b0_0_0_0_0_0_1_00_10_00_0_0_0;
  localparam logic [15:0] O_AWB  = 16'b0_0_0_1_0_1_0_00_00_00_0_0_0;
  localparam logic [15:0] O_BR   = 16'b0_0_0_0_0_0_1_00_01_01_0_1_0;
  localparam logic [15:0] O_AIWB = 16'b0_0_0_0_0_1_0_00_00_00_0_0_0;
  localparam logic [15:0] O_JMP  = 16'b0_0_0_0_0_0_0_00_00_10_1_0_0;

  // Behavioural datapath ALU driven by the control outputs.
  logic [31:0] pc = 32'h100, reg_a, reg_b, sign_imm = 32'h4;
  logic [5:0]  funct;
  logic [31:0] src_a, src_b, alu_res;
  logic        alu_zero;
  always_comb begin
    src_a = aluSrcA_o ? reg_a : pc;
    case (aluSrcB_o)
      2'b00:   src_b = reg_b;
      2'b01:   src_b = 32'd4;
      2'b10:   src_b = sign_imm;
      default: src_b = sign_imm << 2;
    endcase
    case (ALUop_o)
      2'b00:   alu_res = src_a + src_b;
      2'b01:   alu_res = src_a - src_b;
      default: begin
        case (funct)
          6'b100000: alu_res = src_a + src_b;
          6'b100010: alu_res = src_a - src_b;
          6'b100100: alu_res = src_a & src_b;
          6'b100101: alu_res = src_a | src_b;
          6'b101010: alu_res = {31'd0, $signed(src_a) < $signed(src_b)};
          default:   alu_res = 32'd0;
        endcase
      end
    endcase
    alu_zero = (alu_res == 32'd0);
  end

  task automatic test_reset();
    // Reset held with mem_ready_i=1: strobes must stay low.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); rst_i = 1'b1; mem_ready_i = 1'b1; opcode_i = 6'b111111; #1;
      n_vec++;
      if (state_o !== 4'd0 || obs !== O_FN) begin
        n_err++;
        $display("FAIL reset[%0d]: state=%0d outs=%b, want state=0 outs=%b", i, state_o, obs, O_FN);
      end
    end
    @(negedge clk); rst_i = 1'b0; #1;
    n_vec++;
    if (state_o !== 4'd0 || obs !== O_FR) begin
      n_err++;
      $display("FAIL reset_release: state=%0d outs=%b, want state=0 outs=%b", state_o, obs, O_FR);
    end
    @(negedge clk); mem_ready_i = 1'b0; #1;
    n_vec++;
    if (state_o !== 4'd1 || obs !== O_ILL) begin
      n_err++;
      $display("FAIL reset_decode: state=%0d outs=%b, want state=1 outs=%b", state_o, obs, O_ILL);
    end
    @(negedge clk); #1;
    n_vec++;
    if (state_o !== 4'd0 || obs !== O_FN) begin
      n_err++;
      $display("FAIL reset_idle: state=%0d outs=%b, want state=0 outs=%b", state_o, obs, O_FN);
    end
  endtask

  task automatic test_lw_waits();
    logic        rdy [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [3:0]  st  [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
    logic [15:0] ex  [8] = '{O_FR, O_DEC, O_MADR, O_MRD, O_MRD, O_MRD, O_MWB, O_FN};
    opcode_i = 6'b100011;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); mem_ready_i = rdy[i]; #1;
      n_vec++;
      if (state_o !== st[i] || obs !== ex[i]) begin
        n_err++;
        $display("FAIL lw[%0d]: state=%0d outs=%b, want state=%0d outs=%b",
                 i, state_o, obs, st[i], ex[i]);
      end
    end
  endtask

  task automatic test_rtype();
    logic        rdy [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [3:0]  st  [5] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
    logic [15:0] ex  [5] = '{O_FR, O_DEC, O_EXE, O_AWB, O_FN};
    opcode_i = 6'b000000; funct = 6'b100000; reg_a = 32'd9; reg_b = 32'd2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); mem_ready_i = rdy[i]; #1;
      n_vec++;
      if (state_o !== st[i] || obs !== ex[i]) begin
        n_err++;
        $display("FAIL rtype[%0d]: state=%0d outs=%b, want state=%0d outs=%b",
                 i, state_o, obs, st[i], ex[i]);
      end
      if (i == 2) begin
        n_vec++;
        if (alu_res !== 32'd11) begin
          n_err++;
          $display("FAIL rtype_alu: aluResult=%0d, want 11", alu_res);
        end
      end
    end
  endtask

  task automatic test_beq();
    logic        rdy [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [3:0]  st  [4] = '{4'd0, 4'd1, 4'd8, 4'd0};
    logic [15:0] ex  [4] = '{O_FR, O_DEC, O_BR, O_FN};
    opcode_i = 6'b000100; reg_a = 32'h10; reg_b = 32'h10;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); mem_ready_i = rdy[i]; #1;
      n_vec++;
      if (state_o !== st[i] || obs !== ex[i]) begin
        n_err++;
        $display("FAIL beq[%0d]: state=%0d outs=%b, want state=%0d outs=%b",
                 i, state_o, obs, st[i], ex[i]);
      end
      if (i == 2) begin
        n_vec++;
        if (alu_zero !== 1'b1) begin
          n_err++;
          $display("FAIL beq_zero: zero=%b result=%h, want zero=1", alu_zero, alu_res);
        end
      end
    end
  endtask

  task automatic test_illegal();
    logic        rdy [3] = '{1'b1, 1'b0, 1'b0};
    logic [3:0]  st  [3] = '{4'd0, 4'd1, 4'd0};
    logic [15:0] ex  [3] = '{O_FR, O_ILL, O_FN};
    opcode_i = 6'b111111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); mem_ready_i = rdy[i]; #1;
      n_vec++;
      if (state_o !== st[i] || obs !== ex[i]) begin
        n_err++;
        $display("FAIL illegal[%0d]: state=%0d outs=%b, want state=%0d outs=%b",
                 i, state_o, obs, st[i], ex[i]);
      end
    end
  endtask

  task automatic test_addi_jump();
    logic [5:0]  opc [8] = '{6'b001000, 6'b001000, 6'b001000, 6'b001000,
                             6'b000010, 6'b000010, 6'b000010, 6'b000010};
    logic        rdy [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [3:0]  st  [8] = '{4'd0, 4'd1, 4'd9, 4'd10, 4'd0, 4'd1, 4'd11, 4'd0};
    logic [15:0] ex  [8] = '{O_FR, O_DEC, O_MADR, O_AIWB, O_FR, O_DEC, O_JMP, O_FN};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); opcode_i = opc[i]; mem_ready_i = rdy[i]; #1;
      n_vec++;
      if (state_o !== st[i] || obs !== ex[i]) begin
        n_err++;
        $display("FAIL addi_j[%0d]: state=%0d outs=%b, want state=%0d outs=%b",
                 i, state_o, obs, st[i], ex[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    // Zero-wait sw immediately followed by fetch of an R-type.
    logic [5:0]  opc [9] = '{6'b101011, 6'b101011, 6'b101011, 6'b101011,
                             6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000};
    logic        rdy [9] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [3:0]  st  [9] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
    logic [15:0] ex  [9] = '{O_FR, O_DEC, O_MADR, O_MWR, O_FR, O_DEC, O_EXE, O_AWB, O_FN};
    for (int i = 0; i < 9; i++) begin
      @(negedge clk); opcode_i = opc[i]; mem_ready_i = rdy[i]; #1;
      n_vec++;
      if (state_o !== st[i] || obs !== ex[i]) begin
        n_err++;
        $display("FAIL b2b[%0d]: state=%0d outs=%b, want state=%0d outs=%b",
                 i, state_o, obs, st[i], ex[i]);
      end
    end
  endtask

  task automatic test_sw_reset();
    logic        rs  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        rdy [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [3:0]  st  [7] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd0, 4'd0};
    logic [15:0] ex  [7] = '{O_FR, O_DEC, O_MADR, O_MWR, O_FN, O_FN, O_FN};
    opcode_i = 6'b101011;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); rst_i = rs[i]; mem_ready_i = rdy[i]; #1;
      n_vec++;
      if (state_o !== st[i] || obs !== ex[i]) begin
        n_err++;
        $display("FAIL sw_reset[%0d]: state=%0d outs=%b, want state=%0d outs=%b",
                 i, state_o, obs, st[i], ex[i]);
      end
    end
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i       = 1'b1;
    mem_ready_i = 1'b1;
    opcode_i    = 6'b111111;
    funct       = 6'b100000;
    reg_a       = 32'd0;
    reg_b       = 32'd0;
    test_reset();
    test_lw_waits();
    test_rtype();
    test_beq();
    test_illegal();
    test_addi_jump();
    test_back_to_back();
    test_sw_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
